// File: rtl/ariane_axi_mem_responder.sv
// ariane_axi_mem_responder: AXI4 subordinate serving one burst at a time from a 1-cycle-latency single-port SRAM
package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;
  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module ariane_axi_mem_responder #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiUserWidth = 1,
  parameter type         axi_req_t    = ariane_axi::req_t,
  parameter type         axi_rsp_t    = ariane_axi::resp_t,
  parameter int unsigned MemAddrWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  axi_req_t                  axi_req_i,
  output axi_rsp_t                  axi_resp_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [AxiDataWidth-1:0]   mem_wdata_o,
  output logic [AxiDataWidth/8-1:0] mem_be_o,
  input  logic [AxiDataWidth-1:0]   mem_rdata_i
);
  localparam int unsigned Off = $clog2(AxiDataWidth / 8);
  typedef enum logic [2:0] {Idle, WrData, WrResp, RdAddr, RdData} state_e;
  typedef enum logic {PrioWrite, PrioRead} prio_e;
  state_e                  state_q, state_d;
  prio_e                   prio_q, prio_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_q, beat_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    err_q, err_d;
  logic                    fresh_q, fresh_d;
  logic [AxiDataWidth-1:0] rdata_q, rdata_d;
  logic                    grant_w, grant_r, last_beat;
  logic [AxiAddrWidth-1:0] next_addr;
  logic [1:0]              resp;
  logic                    unused_req;
  // Only the handshake-relevant request fields drive logic; the rest are intentionally ignored.
  assign unused_req = ^axi_req_i;
  function automatic logic is_err(input logic [1:0] burst, input logic [2:0] size);
    return burst == 2'b10 || 32'(size) > Off;
  endfunction
  assign last_beat = beat_q == len_q;
  assign next_addr = burst_q == 2'b01 ? addr_q + (AxiAddrWidth'(1) << size_q) : addr_q;
  assign resp      = err_q ? 2'b10 : 2'b00;
  assign grant_w   = axi_req_i.aw_valid && (!axi_req_i.ar_valid || prio_q == PrioWrite);
  assign grant_r   = axi_req_i.ar_valid && !grant_w;
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    fresh_d     = 1'b0;
    rdata_d     = fresh_q ? mem_rdata_i : rdata_q;
    axi_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = addr_q[MemAddrWidth+Off-1:Off];
    mem_wdata_o = axi_req_i.w.data;
    mem_be_o    = axi_req_i.w.strb;
    axi_resp_o.b.id   = id_q;
    axi_resp_o.b.resp = resp;
    axi_resp_o.b.user = {AxiUserWidth{1'b0}};
    axi_resp_o.r.id   = id_q;
    axi_resp_o.r.resp = resp;
    axi_resp_o.r.last = last_beat;
    axi_resp_o.r.user = {AxiUserWidth{1'b0}};
    // The first RD_DATA cycle forwards the SRAM output directly; later cycles replay the captured copy.
    axi_resp_o.r.data = err_q ? '0 : (fresh_q ? mem_rdata_i : rdata_q);
    case (state_q)
      Idle: begin
        axi_resp_o.aw_ready = grant_w;
        axi_resp_o.ar_ready = grant_r;
        if (axi_req_i.aw_valid && axi_req_i.ar_valid) prio_d = grant_w ? PrioRead : PrioWrite;
        if (grant_w) begin
          id_d    = axi_req_i.aw.id;
          addr_d  = axi_req_i.aw.addr;
          len_d   = axi_req_i.aw.len;
          size_d  = axi_req_i.aw.size;
          burst_d = axi_req_i.aw.burst;
          err_d   = is_err(axi_req_i.aw.burst, axi_req_i.aw.size);
          beat_d  = '0;
          state_d = WrData;
        end else if (grant_r) begin
          id_d    = axi_req_i.ar.id;
          addr_d  = axi_req_i.ar.addr;
          len_d   = axi_req_i.ar.len;
          size_d  = axi_req_i.ar.size;
          burst_d = axi_req_i.ar.burst;
          err_d   = is_err(axi_req_i.ar.burst, axi_req_i.ar.size);
          beat_d  = '0;
          state_d = RdAddr;
        end
      end
      WrData: begin
        axi_resp_o.w_ready = 1'b1;
        mem_req_o          = axi_req_i.w_valid && !err_q;
        mem_we_o           = 1'b1;
        if (axi_req_i.w_valid) begin
          addr_d  = next_addr;
          beat_d  = beat_q + 8'd1;
          state_d = last_beat ? WrResp : WrData;
        end
      end
      WrResp: begin
        axi_resp_o.b_valid = 1'b1;
        state_d            = axi_req_i.b_ready ? Idle : WrResp;
      end
      RdAddr: begin
        mem_req_o = !err_q;
        fresh_d   = 1'b1;
        state_d   = RdData;
      end
      RdData: begin
        axi_resp_o.r_valid = 1'b1;
        if (axi_req_i.r_ready) begin
          addr_d  = last_beat ? addr_q : next_addr;
          beat_d  = last_beat ? beat_q : beat_q + 8'd1;
          state_d = last_beat ? Idle : RdAddr;
        end
      end
      default: state_d = Idle;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      prio_q  <= PrioWrite;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      fresh_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      fresh_q <= fresh_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
